// File: rtl/gpio_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpio_apb_ctrl
// Purpose  : APB slave sequencer for the GPIO register block (decode, legality
//            check, read-latency wait, byte-strobe read-modify-write).
// Revision : 1.0  initial release
// ============================================================================
module gpio_apb_ctrl #(
    parameter int          ADDR_W   = 8,
    parameter int          RD_LAT   = 1,
    parameter int unsigned LAST_OFS = 32'h24
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pstrb,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [31:0]       gpio_addr,
    output logic              gpio_we,
    output logic [31:0]       gpio_wdat,
    input  logic [31:0]       gpio_rdat
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_DECODE  = 3'd1;
    localparam logic [2:0] c_RD_WAIT = 3'd2;
    localparam logic [2:0] c_MERGE   = 3'd3;
    localparam logic [2:0] c_WR      = 3'd4;
    localparam logic [2:0] c_RESP    = 3'd5;
    localparam logic [2:0] c_ERR     = 3'd6;
    localparam logic [2:0] c_LAT     = 3'(RD_LAT);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [31:0]       r_wdata;
    logic [3:0]        r_strb;
    logic [31:0]       r_prdata;
    logic              r_pready;
    logic              r_pslverr;
    logic              r_we;
    logic [31:0]       r_wdat;
    logic              w_err;
    logic              w_rd_done;
    logic              w_pready_d;
    logic              w_pslverr_d;
    logic              w_we_d;
    logic [31:0]       w_merged;

    assign w_err = (r_addr[1:0] != 2'b00)
                 || (32'(r_addr) > LAST_OFS)
                 || (r_write && (r_addr == '0));

    assign w_rd_done = (r_state == c_RD_WAIT) && (r_cnt == c_LAT);

    // Strobed bytes come from the captured write data, the rest from the old word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign w_merged[8*gi +: 8] = r_strb[gi] ? r_wdata[8*gi +: 8]
                                                : gpio_rdat[8*gi +: 8];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (psel && !penable) w_next = c_DECODE;
            end
            c_DECODE: begin
                if (w_err)                 w_next = c_ERR;
                else if (!r_write)         w_next = c_RD_WAIT;
                else if (r_strb == 4'hF)   w_next = c_WR;
                else if (r_strb == 4'h0)   w_next = c_RESP;
                else                       w_next = c_RD_WAIT;
            end
            c_RD_WAIT: begin
                if (!psel)          w_next = c_IDLE;
                else if (w_rd_done) w_next = r_write ? c_WR : c_RESP;
            end
            c_MERGE:  w_next = c_WR;
            c_WR:     w_next = psel ? c_RESP : c_IDLE;
            c_RESP:   w_next = c_IDLE;
            c_ERR:    w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear as clean flops.
    always_comb begin
        w_pready_d  = 1'b0;
        w_pslverr_d = 1'b0;
        w_we_d      = 1'b0;
        case (w_next)
            c_RESP:  w_pready_d = 1'b1;
            c_ERR: begin
                w_pready_d  = 1'b1;
                w_pslverr_d = 1'b1;
            end
            c_WR:    w_we_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_we      <= 1'b0;
            r_wdat    <= '0;
        end else begin
            r_pready  <= w_pready_d;
            r_pslverr <= w_pslverr_d;
            r_we      <= w_we_d;
            if ((r_state == c_IDLE) && (w_next == c_DECODE)) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
            end
            if ((r_state == c_RD_WAIT) && (w_next == c_RD_WAIT)) begin
                r_cnt <= r_cnt + 3'd1;
            end else begin
                r_cnt <= '0;
            end
            if (w_rd_done && (w_next == c_RESP)) begin
                r_prdata <= gpio_rdat;
            end
            if (w_next == c_WR) begin
                r_wdat <= (r_state == c_RD_WAIT) ? w_merged : r_wdata;
            end
        end
    end

    assign prdata    = r_prdata;
    assign pready    = r_pready;
    assign pslverr   = r_pslverr;
    assign gpio_addr = 32'(r_addr);
    assign gpio_we   = r_we;
    assign gpio_wdat = r_wdat;

endmodule
`default_nettype wire
